// File: rtl/rf_sram_mp.sv
// Multi-port register file: one SRAM copy per read port plus a dump copy.
// Clears itself after reset, bypasses same-cycle writes, streams a dump.
module rf_sram_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        re,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     we,
  output logic                     busy,
  input  logic                     dump_req,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NCOPY = NUM_RD + 1;
  localparam logic [ADDR_W-1:0] LAST  = '1;
  localparam logic [ADDR_W-1:0] FIRST = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] READY = 2'd1;
  localparam logic [1:0] DUMP  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] dump_ptr;
  logic              clearing;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  logic [NCOPY-1:0][ADDR_W-1:0]  raddr;
  logic [DATA_W-1:0]             q [NCOPY];
  logic [NUM_RD-1:0][DATA_W-1:0] rd_next;
  logic [DATA_W-1:0]             dump_next;

  assign clearing = (state == CLEAR);
  assign raddr    = {dump_ptr, rd_addr};

  // The clear sweep owns the write port of every copy.
  always_comb begin
    ram_we    = we && (wr_addr != '0);
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (clearing) begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr;
      ram_wdata = '0;
    end
  end

  for (genvar g = 0; g < NCOPY; g++) begin : g_copy
    logic [DATA_W-1:0] ram [DEPTH];
    always_ff @(posedge clk)
      if (ram_we) ram[ram_waddr] <= ram_wdata;
    assign q[g] = ram[raddr[g]];
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (raddr[i] == '0)
        rd_next[i] = '0;
      else if (we && (wr_addr == raddr[i]))
        rd_next[i] = wr_data;
      else
        rd_next[i] = q[i];
    end
  end

  assign dump_next = (we && (wr_addr == dump_ptr)) ? wr_data : q[NUM_RD];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (clearing) begin
      rd_data <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++)
        if (re[i]) rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      dump_ptr   <= '0;
      busy       <= 1'b1;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      dump_valid <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (dump_req) begin
            state    <= DUMP;
            dump_ptr <= FIRST;
          end
        end
        DUMP: begin
          dump_valid <= 1'b1;
          dump_addr  <= dump_ptr;
          dump_data  <= dump_next;
          dump_ptr   <= dump_ptr + 1'b1;
          if (dump_ptr == LAST) state <= READY;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_sram_mp.sv
// Randomised and directed checks of rf_sram_mp against an
// array-based model of the register file, clear sweep and dump.
module tb_rf_sram_mp;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rd_addr;
  logic [1:0]  re;
  logic [31:0] rd_data;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        we;
  logic        busy;
  logic        dump_req;
  logic        dump_valid;
  logic [3:0]  dump_addr;
  logic [15:0] dump_data;

  rf_sram_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .re         (re),
    .rd_data    (rd_data),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .we         (we),
    .busy       (busy),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] regs [DEPTH];
  logic [15:0] m_rd [2];
  logic        m_busy;
  logic        m_dv;
  logic [3:0]  m_da;
  logic [15:0] m_dd;
  int          clr_left;
  int          d_left;
  int          d_next;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int a;
    if (clr_left > 0) begin
      clr_left--;
      m_rd[0] = '0;
      m_rd[1] = '0;
      m_dv    = 1'b0;
      d_left  = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (re[i]) begin
          a = int'(rd_addr[i*4 +: 4]);
          if (a == 0)                      m_rd[i] = '0;
          else if (we && wr_addr == 4'(a)) m_rd[i] = wr_data;
          else                             m_rd[i] = regs[a];
        end
      end
      if (d_left > 0) begin
        m_dv = 1'b1;
        m_da = 4'(d_next);
        m_dd = (we && wr_addr == 4'(d_next)) ? wr_data : regs[d_next];
        d_next++;
        d_left--;
      end else begin
        m_dv = 1'b0;
        if (dump_req) begin
          d_left = DEPTH - 1;
          d_next = 1;
        end
      end
      if (we && wr_addr != 4'd0) regs[wr_addr] = wr_data;
    end
    m_busy = (clr_left > 0);
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rd0", 32'(rd_data[15:0]), 32'(m_rd[0]));
    chk("rd1", 32'(rd_data[31:16]), 32'(m_rd[1]));
    chk("dump_valid", 32'(dump_valid), 32'(m_dv));
    if (m_dv) begin
      chk("dump_addr", 32'(dump_addr), 32'(m_da));
      chk("dump_data", 32'(dump_data), 32'(m_dd));
    end
  endtask

  task automatic cyc(input logic w, input logic [3:0] wa,
                     input logic [15:0] wd, input logic [1:0] r,
                     input logic [7:0] ra, input logic dr);
    we       = w;
    wr_addr  = wa;
    wr_data  = wd;
    re       = r;
    rd_addr  = ra;
    dump_req = dr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 16'd0, 2'b00, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < DEPTH; k++) regs[k] = '0;
    m_rd[0]  = '0;
    m_rd[1]  = '0;
    m_busy   = 1'b1;
    m_dv     = 1'b0;
    clr_left = DEPTH;
    d_left   = 0;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_clear(input logic noisy);
    int n;
    n = 0;
    while (busy && n < 40) begin
      if (noisy)
        cyc(1'b1, 4'd5, 16'($urandom), 2'b11, 8'($urandom), 1'b1);
      else
        idle();
      n++;
    end
    chk("clear_len", 32'(n), 32'd16);
  endtask

  int          beats;
  logic [15:0] b8;
  int          guard;

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wr_addr = '0; wr_data = '0;
    re = '0; rd_addr = '0; dump_req = 1'b0;
    @(negedge clk);
    do_reset();
    wait_clear(1'b1);

    cyc(1'b0, 4'd0, 16'd0, 2'b11, {4'd7, 4'd3}, 1'b0);
    chk("clr_r3", 32'(rd_data[15:0]), 32'd0);
    chk("clr_r7", 32'(rd_data[31:16]), 32'd0);

    cyc(1'b1, 4'd5, 16'hBEEF, 2'b00, 8'd0, 1'b0);
    cyc(1'b0, 4'd0, 16'd0, 2'b11, {4'd5, 4'd5}, 1'b0);
    chk("r5_p0", 32'(rd_data[15:0]), 32'hBEEF);
    chk("r5_p1", 32'(rd_data[31:16]), 32'hBEEF);

    cyc(1'b1, 4'd9, 16'h1234, 2'b01, {4'd0, 4'd9}, 1'b0);
    chk("bypass", 32'(rd_data[15:0]), 32'h1234);

    cyc(1'b1, 4'd0, 16'hFFFF, 2'b00, 8'd0, 1'b0);
    cyc(1'b0, 4'd0, 16'd0, 2'b11, {4'd0, 4'd0}, 1'b0);
    chk("r0_p0", 32'(rd_data[15:0]), 32'd0);
    chk("r0_p1", 32'(rd_data[31:16]), 32'd0);
    cyc(1'b0, 4'd0, 16'd0, 2'b11, {4'd5, 4'd5}, 1'b0);
    cyc(1'b0, 4'd0, 16'd0, 2'b00, {4'd9, 4'd9}, 1'b0);
    chk("hold_p0", 32'(rd_data[15:0]), 32'hBEEF);
    chk("hold_p1", 32'(rd_data[31:16]), 32'hBEEF);

    for (int k = 1; k < DEPTH; k++)
      cyc(1'b1, 4'(k), 16'(k * 16'h0101), 2'b00, 8'd0, 1'b0);
    cyc(1'b1, 4'd8, 16'hAAAA, 2'b00, 8'd0, 1'b1);
    beats = 0;
    b8    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idle();
      if (dump_valid) begin
        beats++;
        if (dump_addr == 4'd8) b8 = dump_data;
      end
    end
    chk("beats", 32'(beats), 32'd15);
    chk("beat8", 32'(b8), 32'hAAAA);

    for (int k = 0; k < 3000; k++)
      cyc(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
          8'($urandom), ($urandom_range(0, 19) == 0));

    for (int k = 0; k < 20; k++) idle();
    cyc(1'b0, 4'd0, 16'd0, 2'b00, 8'd0, 1'b1);
    guard = 0;
    while (!(m_dv && m_da == 4'd6) && guard < 20) begin
      idle();
      guard++;
    end
    chk("beat6_seen", 32'(guard < 20), 32'd1);
    do_reset();
    chk("abort_valid", 32'(dump_valid), 32'd0);
    wait_clear(1'b0);
    cyc(1'b0, 4'd0, 16'd0, 2'b11, {4'd5, 4'd5}, 1'b0);
    chk("r5_cleared0", 32'(rd_data[15:0]), 32'd0);
    chk("r5_cleared1", 32'(rd_data[31:16]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_sram_mp.md
# rf_sram_mp

Parametrised multi-port register file built from block-SRAM copies: one copy per read port plus one dump copy, all written in parallel. It sits in the CPU datapath between decode (read ports) and writeback (write port). It adds a hardware clear sweep after reset, same-cycle write-to-read bypass, a hardwired zero register, and a streaming debug dump port that replaces simulation-only `$display` dumps.

## Interface

- `DATA_W`, 16, register width in bits
- `ADDR_W`, 4, address width; `DEPTH = 2**ADDR_W` registers
- `NUM_RD`, 2, number of read ports (≥1); the block instantiates `NUM_RD+1` SRAM copies
- `clk` input 1, single clock; all state updates on posedge
- `rst_n` input 1, asynchronous active-low reset
- `rd_addr` input `NUM_RD*ADDR_W`, packed read addresses; port i uses bits `[i*ADDR_W +: ADDR_W]`
- `re` input `NUM_RD`, per-port read enable
- `rd_data` output `NUM_RD*DATA_W`, packed registered read data
- `wr_addr` input `ADDR_W`, write address
- `wr_data` input `DATA_W`, write data
- `we` input 1, write enable
- `busy` output 1, high while the clear sweep runs
- `dump_req` input 1, starts a register dump
- `dump_valid` output 1, dump beat valid
- `dump_addr` output `ADDR_W`, register index of the current beat
- `dump_data` output `DATA_W`, register contents of the current beat

## Operation

- FSM states: CLEAR, READY, DUMP.
- Reset (`rst_n`=0), asynchronous:
  - state→CLEAR, clear pointer→0
  - `rd_data`, `dump_*` outputs→0
  - `busy`→1
- CLEAR:
  - Each posedge writes 0 to address = clear pointer in all copies, then increments the pointer.
  - After the write to `DEPTH-1`, go to READY and set `busy`=0.
  - `we`, `re` and `dump_req` are ignored; `rd_data` holds 0.
- READY/DUMP, write:
  - `we`=1 with `wr_addr`≠0 writes `wr_data` to all copies.
  - Writes to address 0 are dropped.
- READY/DUMP, read:
  - `re[i]`=1 updates port i at the edge.
  - If `rd_addr[i]`=0, the port returns 0.
  - Else if `we`=1 and `wr_addr`=`rd_addr[i]`, the port returns `wr_data` (bypass).
  - Else the port returns the SRAM contents.
  - `re[i]`=0 holds the previous `rd_data[i]`.
- Dump:
  - `dump_req`=1 in READY enters DUMP.
  - DUMP reads addresses 1..`DEPTH-1` from the dump copy, one per cycle, applying the same bypass rule.
  - Each result is presented as a beat: `dump_valid`=1, with `dump_addr` and `dump_data`.
  - After the last beat is issued, return to READY.
  - `dump_req` is ignored while in DUMP or CLEAR.
  - Normal reads and writes are unaffected by a dump.
- Register 0 reads as 0 on every path. It is never dumped.

## Timing

- Read latency: 1 cycle. Address and `re` sampled at edge N; data visible after edge N.
- Write visible to a same-cycle read via bypass, and to any later read from the SRAM.
- Clear sweep:
  - Takes exactly `DEPTH` posedges after `rst_n` rises.
  - `busy` falls after the `DEPTH`-th edge.
  - The first accepted access is on the next edge.
- Dump beats:
  - `dump_req` sampled at edge N; the first beat (addr 1) is valid after edge N+1.
  - Beats are contiguous for `DEPTH-1` cycles.
  - `dump_valid` drops after edge N+`DEPTH`.
- Reset mid-CLEAR or mid-DUMP aborts immediately. A full clear sweep restarts after `rst_n` rises.
- No backpressure on the dump port; the consumer must accept one beat per cycle.

## Test plan

- Reset then wait: after `rst_n` rises, `busy`=1 for exactly 16 cycles (defaults). Then, for `re`=2'b11 with `rd_addr` = {4'd7, 4'd3}, `rd_data`=0 on both ports.
- Write R5=16'hBEEF. Next cycle, `rd_addr` = {5,5} with `re`=11 → both ports read 16'hBEEF one cycle later.
- Bypass: same cycle `we`=1, `wr_addr`=9, `wr_data`=16'h1234, `rd_addr[0]`=9 → `rd_data[0]`=16'h1234 after that edge.
- Zero register: write 16'hFFFF to R0, then read R0 on both ports → 0. With `re`=0, `rd_data` holds its prior value.
- Dump after writing Rk=k*16'h0101 for k=1..15: pulse `dump_req` → 15 contiguous beats, addr 1..15 with matching data. A write of R8=16'hAAAA on the dump_req cycle appears as 16'hAAAA in beat 8.
- Assert `rst_n`=0 mid-dump at beat 6 → `dump_valid`=0 immediately. A full 16-cycle clear follows, and R5 then reads 0.
